// File: rtl/branch_resolve.sv
// Branch resolution: in-order queue of fetch-time BTB predictions, checked at execute.
// Optional BRU_STATS_EN adds stat_resolved / stat_mispred counters.
module branch_resolve #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic [31:0] push_pc,
    input  logic        push_pred,
    input  logic [31:0] push_target,
    output logic        push_ready,
    input  logic        res_valid,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        btb_en,
    output logic [31:0] btb_pc,
    output logic [31:0] btb_target,
    output logic        btb_taken,
    output logic        res_err
`ifdef BRU_STATS_EN
    ,
    output logic [31:0] stat_resolved,
    output logic [31:0] stat_mispred
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] tgt_mem  [DEPTH];
    logic        pred_mem [DEPTH];

    logic        flush_q, flush_d;
    logic [31:0] redirect_q, redirect_d;
    logic        btb_en_q, btb_en_d;
    logic [31:0] btb_pc_q, btb_pc_d;
    logic [31:0] btb_target_q, btb_target_d;
    logic        btb_taken_q, btb_taken_d;
    logic        res_err_q, res_err_d;

    logic        pop, do_push, mispred;
    logic [31:0] entry_pc, entry_tgt;
    logic        entry_pred;

    assign entry_pc   = pc_mem[rd_ptr_q];
    assign entry_tgt  = tgt_mem[rd_ptr_q];
    assign entry_pred = pred_mem[rd_ptr_q];

    // push_ready uses the pre-pop count, so a full queue drops a push even when popping.
    assign push_ready = (state_q == RUN) && (count_q < FULL);

    always_comb begin
        pop     = (state_q == RUN) && res_valid && (count_q != '0);
        mispred = pop && ((entry_pred != res_taken) ||
                          (entry_pred && res_taken && (entry_tgt != res_target)));
        do_push = push && push_ready && !mispred;

        state_d  = mispred ? FLUSH : RUN;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (mispred) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            unique case ({do_push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end

        flush_d      = mispred;
        redirect_d   = '0;
        if (mispred) redirect_d = res_taken ? res_target : entry_pc + 32'd4;

        btb_en_d     = pop;
        btb_pc_d     = pop ? entry_pc   : btb_pc_q;
        btb_target_d = pop ? res_target : btb_target_q;
        btb_taken_d  = pop ? res_taken  : btb_taken_q;
        res_err_d    = (state_q == RUN) && res_valid && (count_q == '0);
    end

    // NOTE: queue storage has no reset; count/pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr_q]   <= push_pc;
            tgt_mem[wr_ptr_q]  <= push_target;
            pred_mem[wr_ptr_q] <= push_pred;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            btb_en_q     <= 1'b0;
            btb_pc_q     <= '0;
            btb_target_q <= '0;
            btb_taken_q  <= 1'b0;
            res_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            flush_q      <= flush_d;
            redirect_q   <= redirect_d;
            btb_en_q     <= btb_en_d;
            btb_pc_q     <= btb_pc_d;
            btb_target_q <= btb_target_d;
            btb_taken_q  <= btb_taken_d;
            res_err_q    <= res_err_d;
        end
    end

    assign flush       = flush_q;
    assign redirect_pc = redirect_q;
    assign btb_en      = btb_en_q;
    assign btb_pc      = btb_pc_q;
    assign btb_target  = btb_target_q;
    assign btb_taken   = btb_taken_q;
    assign res_err     = res_err_q;

`ifdef BRU_STATS_EN
    logic [31:0] stat_resolved_q, stat_resolved_d;
    logic [31:0] stat_mispred_q, stat_mispred_d;

    always_comb begin
        stat_resolved_d = stat_resolved_q + (pop ? 32'd1 : 32'd0);
        stat_mispred_d  = stat_mispred_q + (mispred ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_resolved_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_resolved_q <= stat_resolved_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_resolved = stat_resolved_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Resolves branches at the execute stage against the predictions made at fetch. Each branch's BTB prediction is held in an in-order queue from decode until execute. At resolution the block compares the prediction with the actual outcome and drives the BTB update port (`en`, `PC`, `PCBranch`, `BranchTaken`). On a misprediction it raises a pipeline flush and a redirect PC. It sits between the decode/execute stages and the BTB update port, and is the write-side counterpart of the BTB lookup.

## Interface
- `DEPTH`, default 4: number of in-flight branch predictions held; power of two, ≥2.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `push` in 1: a decoded branch enters the queue.
- `push_pc` in 32: PC of that branch.
- `push_pred` in 1: BTB prediction taken/not-taken.
- `push_target` in 32: BTB predicted target.
- `push_ready` out 1: the queue accepts a push this cycle.
- `res_valid` in 1: execute resolves the oldest queued branch.
- `res_taken` in 1: actual outcome.
- `res_target` in 32: actual taken target.
- `flush` out 1: one-cycle pulse that squashes younger instructions.
- `redirect_pc` out 32: correct fetch PC; valid while `flush`=1.
- `btb_en` out 1: BTB write enable.
- `btb_pc` out 32: BTB write index PC.
- `btb_target` out 32: BTB write target.
- `btb_taken` out 1: BTB write taken bit.
- `res_err` out 1: one-cycle pulse when `res_valid` arrives with an empty queue.

## Operation
- Circular queue: write pointer, read pointer and a count in the range 0..DEPTH.
- FSM states are RUN and FLUSH. Reset enters RUN.
- **RUN state**
  - `push_ready` = (count < DEPTH).
  - A push when `push_ready`=1 stores {pc, pred, target} at the write pointer. A push when `push_ready`=0 is dropped with no state change.
  - `res_valid` with count > 0 pops the oldest entry.
  - Mispredict = (`pred` ≠ `res_taken`) OR (`pred` & `res_taken` & `target` ≠ `res_target`).
  - Every pop registers a BTB write: `btb_en`=1, `btb_pc`=entry pc, `btb_target`=`res_target`, `btb_taken`=`res_taken`.
  - On a mispredict:
    - Register `flush`=1.
    - Register `redirect_pc` = `res_taken` ? `res_target` : entry pc + 32'd4. The sum wraps modulo 2^32.
    - Clear the whole queue: count=0, pointers equal.
    - Discard any push in the same cycle; it is a wrong-path branch.
    - Next state is FLUSH.
  - A correct prediction causes no flush and leaves the other entries intact.
  - Simultaneous push and non-mispredicting pop: count is unchanged. The pop is allowed even when count=DEPTH, but `push_ready` is still computed from the pre-pop count, so the push is dropped when full.
  - `res_valid` with count=0: no pop, no BTB write, `res_err` pulses next cycle.
- **FLUSH state** (exactly one cycle)
  - `push_ready`=0; pushes are ignored.
  - `res_valid` is ignored: no pop, no error.
  - Unconditional transition to RUN.
- Reset mid-operation empties the queue and forces RUN. In-flight outputs drop immediately.

## Timing
- All outputs are registered except `push_ready`, which is combinational from state and count.
- Reset values:
  - `flush`=0, `redirect_pc`=0, `btb_en`=0, `btb_pc`=0, `btb_target`=0, `btb_taken`=0, `res_err`=0.
  - `push_ready`=1, since the FSM is in RUN with count=0.
- `res_valid` at edge N produces `btb_en`, and `flush`/`redirect_pc` if mispredicted, high for the cycle after edge N. They deassert after edge N+1 unless another event occurs.
- `flush` is high during the cycle in which the FSM is in FLUSH.
- Push-to-resolve minimum latency is 1 cycle: an entry pushed at edge N can be popped at edge N+1.

## Configuration
- `BRU_STATS_EN` defined:
  - Adds outputs `stat_resolved` (out, 32) and `stat_mispred` (out, 32).
  - `stat_resolved` increments on every pop; `stat_mispred` increments on every mispredict.
  - Both wrap at 2^32 and reset to 0.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `reset_n`=0, then release → `push_ready`=1 and all registered outputs are 0.
- **Correct not-taken:** push pc=0x100, pred=0; resolve taken=0 → next cycle `btb_en`=1, `btb_pc`=0x100, `btb_taken`=0, `flush`=0.
- **Mispredict not-taken:** push pc=0x200, pred=0, plus two more entries; resolve taken=1, target=0x400 → next cycle `flush`=1 and `redirect_pc`=0x400. The queue is then empty, `push_ready`=0 for the FLUSH cycle, and a `res_valid` on the following edge produces `res_err`=1.
- **Target mismatch:** push pred=1, target=0x300; resolve taken=1, target=0x304 → `flush`=1 and `redirect_pc`=0x304. Then push pred=1, pc=0xFFFFFFFC; resolve taken=0 → `redirect_pc`=0x00000000 (wrap-around).
- **Full queue:** fill DEPTH=4 entries, then push a fifth → it is dropped with `push_ready`=0. A simultaneous correct pop keeps count at 3 → `push_ready`=1 next cycle.
- **Stats (with `BRU_STATS_EN`):** 5 resolves including 2 mispredicts → `stat_resolved`=5 and `stat_mispred`=2.
